// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock,
// rippling the carry between chunks through a register.
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high. in_ready is high only in IDLE, out_valid only in HOLD; neither side queues.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] partial;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] partial_next;

    always_comb begin
        a_chunk      = a_q[idx*CHUNK +: CHUNK];
        b_chunk      = b_q[idx*CHUNK +: CHUNK];
        chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        partial_next = partial;
        partial_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            partial   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1; the inverted B feeds the overflow rule too.
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        idx      <= '0;
                        partial  <= '0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    partial <= partial_next;
                    carry   <= chunk_sum[CHUNK];
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        sum       <= partial_next;
                        cout      <= chunk_sum[CHUNK];
                        ovf       <= (a_msb == b_msb) && (partial_next[WIDTH-1] != a_msb);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor, the successor of the combinational 4-bit ripple adder. It adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register. It computes A+B+Cin or A−B and reports carry-out and signed overflow. It sits between operand producers and result consumers using valid/ready handshakes on both sides, trading latency for a short carry chain.

## Interface
- WIDTH, 16: operand/result width; must satisfy WIDTH ≥ 1 and WIDTH % CHUNK == 0.
- CHUNK, 4: bits added per cycle; CHUNK ≥ 1. NCHUNK = WIDTH/CHUNK.

- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  reset, asynchronous assert, active-low.
- In_valid  input  1  operand set presented.
- In_ready  output  1  block accepts operands (high only in IDLE).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; used only when Sub=0.
- Sub  input  1  0: A+B+Cin; 1: A+~B+1 (A−B), Cin ignored.
- Out_valid  output  1  result registers hold a completed result.
- Out_ready  input  1  consumer takes result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out of bit WIDTH−1 (for Sub: 1 = no borrow).
- Ovf  output  1  two's-complement overflow.

## Operation
- States: IDLE, ADD, HOLD. Counter idx, width clog2(NCHUNK) (min 1).
- IDLE: In_ready=1. On In_valid=1 at an edge: capture A, B' = Sub ? ~B : B, carry = Sub ? 1 : Cin, and the operand MSBs a_msb, b'_msb. Set idx=0 and go to ADD.
- ADD: each cycle {c, s} = A_chunk[idx] + B'_chunk[idx] + carry, computed at CHUNK+1 bits. Write s into partial-sum chunk idx, carry ← c, idx ← idx+1.
  - On the edge that processes chunk NCHUNK−1, load the output registers and go to HOLD:
    - Sum ← full partial sum.
    - Cout ← c.
    - Ovf ← (a_msb == b'_msb) && (Sum[WIDTH−1] != a_msb).
- HOLD: Out_valid=1. Sum/Cout/Ovf are stable. In_ready=0; In_valid is ignored. On Out_ready=1 at an edge, go to IDLE.
- Sum, Cout and Ovf change only on entry to HOLD. They keep the last result after leaving HOLD and never show partial sums.
- Operand inputs are sampled only at the accepting edge; later changes to A, B, Cin or Sub have no effect.
- Rst_n low, at any time including mid-ADD or HOLD:
  - State goes to IDLE and the in-flight operation is discarded.
  - Sum=0, Cout=0, Ovf=0, Out_valid=0, In_ready=1, internal carry/idx/partial cleared.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Accept at edge T0 (IDLE, In_valid=1). The block is in ADD for edges T0+1 … T0+NCHUNK. Out_valid=1 and results are valid from edge T0+NCHUNK.
  - Latency: NCHUNK cycles from accept to Out_valid.
- Release: Out_ready=1 sampled at edge Tr in HOLD gives Out_valid=0 and In_ready=1 from Tr. The next accept happens at Tr+1 at the earliest.
  - Max throughput: one operation per NCHUNK+2 cycles.
- CHUNK=WIDTH: single ADD cycle; Out_valid at T0+1.
- Out_ready in IDLE or ADD is ignored. In_valid in ADD or HOLD is ignored; it is neither queued nor lost-flagged.
- Out_valid held with Out_ready=0: the block stays in HOLD indefinitely.

## Test plan
- WIDTH=16, CHUNK=4: accept A=0x1234, B=0x0FFF, Cin=0, Sub=0 → Out_valid exactly 4 cycles after accept. Expect Sum=0x2233, Cout=0, Ovf=0.
- Carry across all chunks: A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1, Ovf=0. Then A=0x7FFF, B=0x0000, Cin=1 → Sum=0x8000, Cout=0, Ovf=1.
- Subtract: A=0x0005, B=0x0007, Sub=1, Cin=1 → Sum=0xFFFE, Cout=0, Ovf=0 (Cin ignored). Then A=0x8000, B=0x0001, Sub=1 → Sum=0x7FFF, Cout=1, Ovf=1.
- Backpressure: hold Out_ready=0 for 10 cycles while toggling A/B/In_valid.
  - Expect Sum/Cout/Ovf stable, In_ready=0, and no new accept.
  - Raise Out_ready → Out_valid=0 and In_ready=1 next edge. The next op result is unaffected by the stimulus applied during HOLD.
- Reset mid-ADD: accept, then pull Rst_n low asynchronously after 2 cycles.
  - Expect Out_valid=0, Sum=0, Cout=0, Ovf=0, In_ready=1 immediately, before the next edge.
  - After release, a fresh op (0x0001+0x0001) gives 0x0002 with the carry cleared.
- Configurations CHUNK=16 and CHUNK=1 (WIDTH=16): random 1000 ops vs reference model, including Sub and Cin. Check latency 1 and 16 cycles respectively and exact Sum/Cout/Ovf match.
